iterative_barrel_shifter: RTL and testbench

//  Multi-cycle parametrised shifter for the ALU datapath. Performs one logarithmic stage per clock: stage k

---
 rtl/shifter_pkg.sv | 17 +
 rtl/shift_stage.sv | 36 +++
 rtl/iterative_barrel_shifter.sv | 103 ++++++++++
 tb/tb_iterative_barrel_shifter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types for the iterative barrel shifter: operation encoding and FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROL = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_stage.sv
// One logarithmic shift stage: shifts din by 2^k according to op when en is high.
// Every power-of-two shift is built with constant slices; k picks one at run time.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   din,
  input  shift_op_e          op,
  input  logic               en,
  input  logic [SHAMT_W-1:0] k,
  output logic [WIDTH-1:0]   dout
);

  logic [WIDTH-1:0] cand [SHAMT_W];

  for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
    localparam int S = 1 << gi;
    assign cand[gi] =
      (op == SH_SLL) ? {din[WIDTH-1-S:0], {S{1'b0}}} :
      (op == SH_SRL) ? {{S{1'b0}}, din[WIDTH-1:S]} :
      (op == SH_SRA) ? {{S{din[WIDTH-1]}}, din[WIDTH-1:S]} :
                       {din[WIDTH-1-S:0], din[WIDTH-1:WIDTH-S]};
  end

  always_comb begin
    dout = din;
    if (en) begin
      for (int i = 0; i < SHAMT_W; i++) begin
        if (k == SHAMT_W'(i)) dout = cand[i];
      end
    end
  end

endmodule

// File: rtl/iterative_barrel_shifter.sv
// Multi-cycle barrel shifter, one log stage per clock, valid/ready on both sides.
// Optional SHIFTER_EARLY_EXIT_EN: leave SHIFT once no higher shamt bits remain.
module iterative_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  state_e             state_reg, state_next;
  logic [SHAMT_W-1:0] cnt_reg, cnt_next;
  logic [SHAMT_W-1:0] shamt_reg, shamt_next;
  shift_op_e          op_reg, op_next;
  logic [WIDTH-1:0]   work_reg, work_next;
  logic [WIDTH-1:0]   stage_dout;
  logic [SHAMT_W-1:0] pending;
  logic               stage_en;
  logic               last_stage;

  // Bit 0 of pending is the current stage's enable; the rest are stages still to come.
  assign pending  = shamt_reg >> cnt_reg;
  assign stage_en = pending[0];

`ifdef SHIFTER_EARLY_EXIT_EN
  assign last_stage = (pending >> 1) == '0;
`else
  assign last_stage = cnt_reg == SHAMT_W'(SHAMT_W - 1);
`endif

  shift_stage #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_stage (
    .din (work_reg),
    .op  (op_reg),
    .en  (stage_en),
    .k   (cnt_reg),
    .dout(stage_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shamt_reg <= '0;
      op_reg    <= SH_SLL;
      work_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shamt_reg <= shamt_next;
      op_reg    <= op_next;
      work_reg  <= work_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shamt_next = shamt_reg;
    op_next    = op_reg;
    work_next  = work_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_next  = in_data;
          shamt_next = in_shamt;
          op_next    = shift_op_e'(in_op);
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        work_next = stage_dout;
        cnt_next  = cnt_reg + SHAMT_W'(1);
        if (last_stage) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Only a finished result is ever visible on out_data.
  assign out_data = (state_reg == DONE) ? work_reg : '0;

endmodule

// File: tb/tb_iterative_barrel_shifter.sv
// Directed and random-sweep checks for iterative_barrel_shifter (WIDTH=32).
module tb_iterative_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int n_compared   = 0;
  int n_mismatched = 0;
  int n_acc = 0;
  int n_ret = 0;

  iterative_barrel_shifter #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid && in_ready) n_acc <= n_acc + 1;
    if (out_valid && out_ready) n_ret <= n_ret + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(logic [31:0] d, logic [4:0] s, logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = 32'($signed(d) >>> s);
      default: r = (s == 5'd0) ? d : ((d << s) | (d >> (6'd32 - {1'b0, s})));
    endcase
    return r;
  endfunction

  function automatic int exp_lat(logic [4:0] s);
`ifdef SHIFTER_EARLY_EXIT_EN
    for (int i = 4; i >= 0; i--) begin
      if (s[i]) return i + 1;
    end
    return 1;
`else
    return 5;
`endif
  endfunction

  task automatic accept_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_op    = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = 5'($urandom);
    in_op    = 2'($urandom);
  endtask

  task automatic wait_valid(input bit rnd, output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rnd) out_ready = 1'($urandom);
      if (out_valid) break;
    end
    if (!out_valid) check("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic release_result(input bit rnd);
    int  guard = 0;
    bit  hs;
    if (!rnd) out_ready = 1'b1;
    while (guard < 40) begin
      hs = out_valid && out_ready;
      @(posedge clk);
      if (hs) break;
      @(negedge clk);
      if (rnd) out_ready = 1'($urandom);
      guard++;
    end
    if (guard >= 40) check("release_timeout", 32'(guard), 32'd0);
    #1;
    out_ready = rnd ? 1'($urandom) : 1'b0;
  endtask

  task automatic directed(input string tag, input logic [31:0] d, input logic [4:0] s,
                          input logic [1:0] op, input logic [31:0] exp);
    int lat;
    out_ready = 1'b0;
    accept_op(d, s, op);
    wait_valid(1'b0, lat);
    check(tag, out_data, exp);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat(s)));
    $display("op %s data=%08h shamt=%0d op=%0d -> %08h lat=%0d", tag, d, s, op, out_data, lat);
    release_result(1'b0);
    @(negedge clk);
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    int          a0, r0;
    logic [31:0] d, held;
    logic [4:0]  s;
    logic [1:0]  op;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;

    // Reset during SHIFT aborts the operation immediately.
    accept_op(32'hFFFF_0000, 5'd4, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    directed("after_rst_sll", 32'hFFFF_0000, 5'd4, 2'b00, 32'hFFF0_0000);

    directed("sll31",    32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
    directed("sra4",     32'h8000_00F0, 5'd4,  2'b10, 32'hF800_000F);
    directed("srl4",     32'h8000_00F0, 5'd4,  2'b01, 32'h0800_000F);
    directed("rol1",     32'h8000_0001, 5'd1,  2'b11, 32'h0000_0003);
    directed("rol0",     32'h8000_0001, 5'd0,  2'b11, 32'h8000_0001);
    directed("rol31",    32'h8000_0001, 5'd31, 2'b11, 32'hC000_0000);
    directed("sra31",    32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
    directed("srl31",    32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001);
    directed("sll0",     32'hA5A5_5A5A, 5'd0,  2'b00, 32'hA5A5_5A5A);

    // Back-pressure: result must hold and new requests must be ignored.
    a0 = n_acc;
    out_ready = 1'b0;
    accept_op(32'h1234_5678, 5'd8, 2'b11);
    wait_valid(1'b0, lat);
    held = out_data;
    check("bp_result", held, 32'h3456_7812);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      in_shamt = 5'(i);
      in_op    = 2'b00;
      @(negedge clk);
      check("bp_stable", out_data, 32'h3456_7812);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    release_result(1'b0);
    @(negedge clk);
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    check("bp_accept_count", 32'(n_acc - a0), 32'd1);
    $display("op backpressure data=12345678 shamt=8 op=3 -> %08h", held);

    // Random sweep with random out_ready.
    a0 = n_acc;
    r0 = n_ret;
    for (int i = 0; i < 2000; i++) begin
      d  = $urandom;
      s  = 5'($urandom);
      op = 2'($urandom);
      accept_op(d, s, op);
      wait_valid(1'b1, lat);
      check("rand_data", out_data, ref_shift(d, s, op));
      check("rand_lat", 32'(lat), 32'(exp_lat(s)));
      $display("op rand%0d data=%08h shamt=%0d op=%0d -> %08h lat=%0d", i, d, s, op, out_data, lat);
      release_result(1'b1);
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("rand_accepts", 32'(n_acc - a0), 32'd2000);
    check("rand_returns", 32'(n_ret - r0), 32'd2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
